// File: rtl/stream_demux_1ton_if.sv
// Bundles the producer-side stream, the N consumer channels and the status outputs of the demux.
// Pure wiring, so there is no latency through the interface itself.
// Backpressure is carried by in_ready toward the producer and by out_ready from each consumer.
`timescale 1ns/1ps
interface stream_demux_1ton_if #(
   parameter int DATA_W = 8,
   parameter int N_CH   = 4,
   parameter int SEL_W  = 2,
   parameter int CNT_W  = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_W-1:0]        in_data;
   logic [SEL_W-1:0]         in_sel;
   logic                     in_last;
   logic [N_CH-1:0]          out_valid;
   logic [N_CH-1:0]          out_ready;
   logic [N_CH*DATA_W-1:0]   out_data;
   logic [N_CH-1:0]          out_last;
   logic                     busy;
   logic [CNT_W-1:0]         drop_cnt;

   // Producer and consumers (testbench or surrounding datapath)
   modport master (
      output in_valid, in_data, in_sel, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy, drop_cnt
   );

   // The demux itself
   modport slave (
      input  in_valid, in_data, in_sel, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, busy, drop_cnt
   );
endinterface

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N packet demux: select- or round-robin-routed, destination locked per packet.
// Latency 1 cycle from input accept to out_valid of the destination channel.
// in_ready follows only the current destination slot (combinational); out-of-range beats are dropped.
`timescale 1ns/1ps
module stream_demux_1ton #(
   parameter int DATA_W = 8,
   parameter int N_CH   = 4,
   parameter int SEL_W  = 2,
   parameter int MODE   = 0,
   parameter int CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   stream_demux_1ton_if.slave   s_if
);

   localparam int               NP       = 1 << SEL_W;
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {ST_IDLE, ST_PKT} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SEL_W-1:0]       r_dest;
   logic [SEL_W-1:0]       w_dest_nxt;
   logic [SEL_W-1:0]       r_rr_ptr;
   logic [SEL_W-1:0]       w_rr_nxt;
   logic [SEL_W-1:0]       w_dest;
   logic                   w_drop;
   logic                   w_acc;
   logic [NP-1:0]          w_full;
   logic [NP-1:0]          w_rdy;
   logic [N_CH-1:0]        r_out_valid;
   logic [N_CH-1:0]        r_out_last;
   logic [N_CH*DATA_W-1:0] r_out_data;
   logic [CNT_W-1:0]       r_drop_cnt;

   // Destination of the current beat: fresh choice on a first beat, locked value mid-packet
   always_comb begin
      w_dest = r_dest;
      if (r_state == ST_IDLE) begin
         w_dest = (MODE != 0) ? r_rr_ptr : s_if.in_sel;
      end
   end

   assign w_drop = (int'(w_dest) >= N_CH);

   // Widen per-channel status to the full select range so any w_dest indexes safely
   always_comb begin
      w_full             = '0;
      w_rdy              = '0;
      w_full[N_CH-1:0]   = r_out_valid;
      w_rdy[N_CH-1:0]    = s_if.out_ready;
   end

   // A slot being drained this cycle can take a new beat, hence out_ready in the path
   assign s_if.in_ready = w_drop | ~w_full[w_dest] | w_rdy[w_dest];
   assign w_acc         = s_if.in_valid & s_if.in_ready;

   // FSM, destination lock and round-robin pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_dest   <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_dest   <= w_dest_nxt;
         r_rr_ptr <= w_rr_nxt;
      end
   end

   // Next state: lock on an accepted non-last first beat, release on an accepted last beat
   always_comb begin
      w_state_nxt = r_state;
      w_dest_nxt  = r_dest;
      w_rr_nxt    = r_rr_ptr;
      if (w_acc) begin
         if (s_if.in_last) begin
            w_state_nxt = ST_IDLE;
            if ((MODE != 0) && !w_drop) begin
               w_rr_nxt = (r_rr_ptr == LAST_CH) ? '0 : r_rr_ptr + 1'b1;
            end
         end else if (r_state == ST_IDLE) begin
            w_state_nxt = ST_PKT;
            w_dest_nxt  = w_dest;
         end
      end
   end

   // One-entry output register per channel; loads on accept, empties on consumer handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= '0;
         r_out_last  <= '0;
         r_out_data  <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_acc && !w_drop && (int'(w_dest) == i)) begin
               r_out_valid[i]                 <= 1'b1;
               r_out_last[i]                  <= s_if.in_last;
               r_out_data[i*DATA_W +: DATA_W] <= s_if.in_data;
            end else if (s_if.out_ready[i]) begin
               r_out_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Saturating count of beats discarded for an out-of-range destination
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_cnt <= '0;
      end else if (w_acc && w_drop && (r_drop_cnt != CNT_MAX)) begin
         r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   assign s_if.out_valid = r_out_valid;
   assign s_if.out_last  = r_out_last;
   assign s_if.out_data  = r_out_data;
   assign s_if.busy      = (r_state == ST_PKT);
   assign s_if.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Self-checking bench: three demux instances (select-driven N=4, select-driven N=3, round-robin N=4).
// Per-channel scoreboards are filled on input accept and drained on output handshake.
// Inline checks cover reset, routing, locking, backpressure, drops, saturation and round-robin.
`timescale 1ns/1ps
module tb_stream_demux_1ton;

   logic clk = 1'b0;
   logic rst_n0, rst_n1, rst_n2;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [8:0] sb0 [4][$];
   logic [8:0] sb2 [4][$];
   logic [8:0] m_exp, m_got;

   always #5 clk = ~clk;

   stream_demux_1ton_if #(.DATA_W(8), .N_CH(4), .SEL_W(2), .CNT_W(8)) if0 ();
   stream_demux_1ton_if #(.DATA_W(8), .N_CH(3), .SEL_W(2), .CNT_W(8)) if1 ();
   stream_demux_1ton_if #(.DATA_W(8), .N_CH(4), .SEL_W(2), .CNT_W(8)) if2 ();

   stream_demux_1ton #(.DATA_W(8), .N_CH(4), .SEL_W(2), .MODE(0), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n0), .s_if(if0.slave));
   stream_demux_1ton #(.DATA_W(8), .N_CH(3), .SEL_W(2), .MODE(0), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n1), .s_if(if1.slave));
   stream_demux_1ton #(.DATA_W(8), .N_CH(4), .SEL_W(2), .MODE(1), .CNT_W(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n2), .s_if(if2.slave));

   // Output monitor: every consumer handshake pops and compares the channel scoreboard
   always @(negedge clk) begin
      for (int c = 0; c < 4; c++) begin
         if (if0.out_valid[c] && if0.out_ready[c]) begin
            n_cmp++;
            m_got = {if0.out_last[c], if0.out_data[c*8 +: 8]};
            if (sb0[c].size() == 0) begin
               n_err++;
               $display("FAIL sb0_unexpected ch%0d got %h required nothing", c, m_got);
            end else begin
               m_exp = sb0[c].pop_front();
               if (m_got !== m_exp) begin
                  n_err++;
                  $display("FAIL sb0_data ch%0d got %h required %h", c, m_got, m_exp);
               end
            end
         end
         if (if2.out_valid[c] && if2.out_ready[c]) begin
            n_cmp++;
            m_got = {if2.out_last[c], if2.out_data[c*8 +: 8]};
            if (sb2[c].size() == 0) begin
               n_err++;
               $display("FAIL sb2_unexpected ch%0d got %h required nothing", c, m_got);
            end else begin
               m_exp = sb2[c].pop_front();
               if (m_got !== m_exp) begin
                  n_err++;
                  $display("FAIL sb2_data ch%0d got %h required %h", c, m_got, m_exp);
               end
            end
         end
      end
   end

   task automatic send0(input int ch, input logic [1:0] sel, input logic [7:0] d, input logic last);
      int   t;
      logic done;
      if0.in_sel = sel; if0.in_data = d; if0.in_last = last; if0.in_valid = 1'b1;
      done = 1'b0; t = 0;
      while (!done && t < 50) begin
         @(negedge clk);
         if (if0.in_ready) begin
            sb0[ch].push_back({last, d});
            done = 1'b1;
         end
         @(posedge clk); #1;
         t++;
      end
      if0.in_valid = 1'b0;
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL send0_timeout ch%0d got no in_ready required accept within 50 cycles", ch);
      end
   endtask

   task automatic send2(input int ch, input logic [7:0] d);
      int   t;
      logic done;
      if2.in_sel = 2'd0; if2.in_data = d; if2.in_last = 1'b1; if2.in_valid = 1'b1;
      done = 1'b0; t = 0;
      while (!done && t < 50) begin
         @(negedge clk);
         if (if2.in_ready) begin
            sb2[ch].push_back({1'b1, d});
            done = 1'b1;
         end
         @(posedge clk); #1;
         t++;
      end
      if2.in_valid = 1'b0;
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL send2_timeout ch%0d got no in_ready required accept within 50 cycles", ch);
      end
   endtask

   task automatic test_reset();
      rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
      if0.in_valid = 0; if0.in_data = 0; if0.in_sel = 0; if0.in_last = 0; if0.out_ready = 4'hF;
      if1.in_valid = 0; if1.in_data = 0; if1.in_sel = 0; if1.in_last = 0; if1.out_ready = 3'h7;
      if2.in_valid = 0; if2.in_data = 0; if2.in_sel = 0; if2.in_last = 0; if2.out_ready = 4'hF;
      repeat (2) @(posedge clk);
      #2;
      rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;
      @(negedge clk);
      n_cmp++; if (if0.out_valid !== 4'b0) begin n_err++; $display("FAIL rst_valid got %b required 0000", if0.out_valid); end
      n_cmp++; if (if0.out_data !== 32'h0) begin n_err++; $display("FAIL rst_data got %h required 0", if0.out_data); end
      n_cmp++; if (if0.out_last !== 4'b0) begin n_err++; $display("FAIL rst_last got %b required 0000", if0.out_last); end
      n_cmp++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b required 0", if0.busy); end
      n_cmp++; if (if1.drop_cnt !== 8'd0) begin n_err++; $display("FAIL rst_drop got %0d required 0", if1.drop_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_routing();
      for (int s = 0; s < 4; s++) begin
         send0(s, 2'(s), 8'hA0 + 8'(s), 1'b1);
         n_cmp++;
         if (if0.out_valid !== (4'b0001 << s)) begin
            n_err++; $display("FAIL route_valid s=%0d got %b required %b", s, if0.out_valid, 4'b0001 << s);
         end
         n_cmp++;
         if (if0.out_data[s*8 +: 8] !== 8'hA0 + 8'(s)) begin
            n_err++; $display("FAIL route_data s=%0d got %h required %h", s, if0.out_data[s*8 +: 8], 8'hA0 + 8'(s));
         end
      end
   endtask

   task automatic test_packet_lock();
      send0(2, 2'd2, 8'hB0, 1'b0);
      n_cmp++; if (if0.busy !== 1'b1) begin n_err++; $display("FAIL lock_busy1 got %b required 1", if0.busy); end
      send0(2, 2'd0, 8'hB1, 1'b0);
      n_cmp++; if (if0.out_valid !== 4'b0100) begin n_err++; $display("FAIL lock_valid2 got %b required 0100", if0.out_valid); end
      send0(2, 2'd0, 8'hB2, 1'b1);
      n_cmp++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL lock_busy3 got %b required 0", if0.busy); end
      n_cmp++; if (if0.out_valid !== 4'b0100) begin n_err++; $display("FAIL lock_valid3 got %b required 0100", if0.out_valid); end
   endtask

   task automatic test_backpressure();
      if0.out_ready = 4'b1101;
      send0(1, 2'd1, 8'hC0, 1'b1);
      send0(3, 2'd3, 8'hC3, 1'b1);
      n_cmp++; if (if0.out_valid !== 4'b1010) begin n_err++; $display("FAIL bp_pass got %b required 1010", if0.out_valid); end
      n_cmp++; if (if0.out_data[15:8] !== 8'hC0) begin n_err++; $display("FAIL bp_hold got %h required c0", if0.out_data[15:8]); end
      if0.in_sel = 2'd1; if0.in_data = 8'hC1; if0.in_last = 1'b1; if0.in_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         n_cmp++; if (if0.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall got %b required 0", if0.in_ready); end
      end
      @(posedge clk); #1;
      if0.out_ready = 4'b1111;
      #1;
      n_cmp++;
      if (if0.in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_release got %b required 1", if0.in_ready);
      end else begin
         sb0[1].push_back({1'b1, 8'hC1});
      end
      @(posedge clk); #1;
      if0.in_valid = 1'b0;
      n_cmp++; if (if0.out_valid[1] !== 1'b1) begin n_err++; $display("FAIL bp_second_vld got %b required 1", if0.out_valid[1]); end
      n_cmp++; if (if0.out_data[15:8] !== 8'hC1) begin n_err++; $display("FAIL bp_second_dat got %h required c1", if0.out_data[15:8]); end
   endtask

   task automatic test_drop();
      if1.in_sel = 2'd3; if1.in_data = 8'h55; if1.in_last = 1'b0; if1.in_valid = 1'b1;
      @(negedge clk);
      n_cmp++; if (if1.in_ready !== 1'b1) begin n_err++; $display("FAIL drop_rdy1 got %b required 1", if1.in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (if1.busy !== 1'b1) begin n_err++; $display("FAIL drop_busy got %b required 1", if1.busy); end
      n_cmp++; if (if1.out_valid !== 3'b000) begin n_err++; $display("FAIL drop_vld1 got %b required 000", if1.out_valid); end
      if1.in_sel = 2'd0; if1.in_last = 1'b1;
      @(negedge clk);
      n_cmp++; if (if1.in_ready !== 1'b1) begin n_err++; $display("FAIL drop_rdy2 got %b required 1", if1.in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (if1.out_valid !== 3'b000) begin n_err++; $display("FAIL drop_vld2 got %b required 000", if1.out_valid); end
      n_cmp++; if (if1.drop_cnt !== 8'd2) begin n_err++; $display("FAIL drop_cnt2 got %0d required 2", if1.drop_cnt); end
      n_cmp++; if (if1.busy !== 1'b0) begin n_err++; $display("FAIL drop_idle got %b required 0", if1.busy); end
      if1.in_sel = 2'd3;
      repeat (252) @(posedge clk);
      #1;
      n_cmp++; if (if1.drop_cnt !== 8'd254) begin n_err++; $display("FAIL drop_cnt254 got %0d required 254", if1.drop_cnt); end
      repeat (48) @(posedge clk);
      #1;
      if1.in_valid = 1'b0;
      n_cmp++; if (if1.drop_cnt !== 8'd255) begin n_err++; $display("FAIL drop_sat got %0d required 255", if1.drop_cnt); end
   endtask

   task automatic test_round_robin();
      for (int k = 0; k < 5; k++) begin
         send2(k % 4, 8'h60 + 8'(k));
         n_cmp++;
         if (if2.out_valid !== (4'b0001 << (k % 4))) begin
            n_err++; $display("FAIL rr_ch k=%0d got %b required %b", k, if2.out_valid, 4'b0001 << (k % 4));
         end
      end
      send2(1, 8'h70);
      send2(2, 8'h71);
      n_cmp++; if (if2.out_valid !== 4'b0100) begin n_err++; $display("FAIL rr_pre_rst got %b required 0100", if2.out_valid); end
      @(posedge clk); #2;
      rst_n2 = 1'b0;
      #2;
      rst_n2 = 1'b1;
      for (int c = 0; c < 4; c++) sb2[c].delete();
      @(posedge clk); #1;
      send2(0, 8'h72);
      n_cmp++; if (if2.out_valid !== 4'b0001) begin n_err++; $display("FAIL rr_post_rst got %b required 0001", if2.out_valid); end
   endtask

   task automatic test_async_reset();
      if0.out_ready = 4'b1110;
      send0(0, 2'd0, 8'hD0, 1'b1);
      send0(2, 2'd2, 8'hD1, 1'b0);
      n_cmp++; if (if0.busy !== 1'b1) begin n_err++; $display("FAIL arst_pre_busy got %b required 1", if0.busy); end
      #2;
      rst_n0 = 1'b0; rst_n1 = 1'b0;
      #1;
      n_cmp++; if (if0.out_valid !== 4'b0) begin n_err++; $display("FAIL arst_valid got %b required 0000", if0.out_valid); end
      n_cmp++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got %b required 0", if0.busy); end
      n_cmp++; if (if1.drop_cnt !== 8'd0) begin n_err++; $display("FAIL arst_drop got %0d required 0", if1.drop_cnt); end
      for (int c = 0; c < 4; c++) sb0[c].delete();
      #3;
      rst_n0 = 1'b1; rst_n1 = 1'b1;
      if0.out_ready = 4'hF;
      @(posedge clk); #1;
      send0(3, 2'd3, 8'hE0, 1'b1);
      n_cmp++; if (if0.out_valid !== 4'b1000) begin n_err++; $display("FAIL arst_first got %b required 1000", if0.out_valid); end
      n_cmp++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL arst_first_busy got %b required 0", if0.busy); end
   endtask

   task automatic test_drain();
      int left;
      repeat (3) @(posedge clk);
      #1;
      left = 0;
      for (int c = 0; c < 4; c++) left += sb0[c].size() + sb2[c].size();
      n_cmp++;
      if (left != 0) begin n_err++; $display("FAIL drain_left got %0d entries required 0", left); end
   endtask

   initial begin
      test_reset();
      test_routing();
      test_packet_lock();
      test_backpressure();
      test_drop();
      test_round_robin();
      test_async_reset();
      test_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
